// File: rtl/truth_table_sweeper_pkg.sv
// Shared state encoding and default parameters for the truth-table sweeper.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  localparam int N_IN_DEF   = 3;
  localparam int SETTLE_DEF = 2;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/result bundle between the controlling logic and the sweeper.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int W = 2**N_IN;

  logic          start;
  logic          abort;
  logic [W-1:0]  expected;
  logic          busy;
  logic          done;
  logic [W-1:0]  table_out;
  logic          match;
  logic [N_IN:0] ones_cnt;

  modport master (
    output start, abort, expected,
    input  busy, done, table_out, match, ones_cnt
  );

  modport slave (
    input  start, abort, expected,
    output busy, done, table_out, match, ones_cnt
  );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down counter: holds each vector for SETTLE cycles before sampling.
module truth_table_sweeper_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);
  localparam int W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Loading SETTLE-1 makes the zero flag appear on the SETTLE-th held cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(SETTLE - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps an external N-input function through every input vector, builds its
// truth table, and compares it against a captured expected mask.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  truth_table_sweeper_if.slave ctl,
  input  logic                f_in_i,
  output logic [N_IN-1:0]     vec_out_o
);
  localparam int W = 2**N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [W-1:0]    tbl_q, tbl_d;
  logic [W-1:0]    exp_q, exp_d;
  logic            done_q, done_d;
  logic            match_q, match_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic [W-1:0]    tbl_final;
  logic [N_IN:0]   ones_final;
  logic            tmr_load, tmr_zero;

  truth_table_sweeper_settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .en_i   (state_q == ST_APPLY),
    .zero_o (tmr_zero)
  );

  // Table as it will look once the last vector is sampled; feeds match/popcount.
  always_comb begin
    tbl_final           = tbl_q;
    tbl_final[W-1]      = f_in_i;
    ones_final          = '0;
    for (int i = 0; i < W; i++) begin
      ones_final = ones_final + (N_IN+1)'(tbl_final[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    tbl_d    = tbl_q;
    exp_d    = exp_q;
    done_d   = 1'b0;
    match_d  = match_q;
    ones_d   = ones_q;
    tmr_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctl.start) begin
          state_d  = ST_APPLY;
          vec_d    = '0;
          tbl_d    = '0;
          exp_d    = ctl.expected;
          match_d  = 1'b0;
          ones_d   = '0;
          tmr_load = 1'b1;
        end
      end
      ST_APPLY: begin
        if (ctl.abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
          match_d = 1'b0;
        end else if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (ctl.abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
          match_d = 1'b0;
        end else if (vec_q != VEC_LAST) begin
          tbl_d[vec_q] = f_in_i;
          vec_d        = vec_q + 1'b1;
          state_d      = ST_APPLY;
          tmr_load     = 1'b1;
        end else begin
          tbl_d   = tbl_final;
          vec_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
          match_d = (tbl_final == exp_q);
          ones_d  = ones_final;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      tbl_q   <= '0;
      exp_q   <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      tbl_q   <= tbl_d;
      exp_q   <= exp_d;
      done_q  <= done_d;
      match_q <= match_d;
      ones_q  <= ones_d;
    end
  end

  assign vec_out_o     = vec_q;
  assign ctl.busy      = (state_q != ST_IDLE);
  assign ctl.done      = done_q;
  assign ctl.table_out = tbl_q;
  assign ctl.match     = match_q;
  assign ctl.ones_cnt  = ones_q;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer for a small combinational logic function under test (N-input SOP gate network, single output).
- On start, drives every input vector 0..2^N-1 in ascending order and waits a settle time after each.
- Samples the function output for each vector and assembles the truth table.
- Compares the table against an expected mask and reports a ones count; sits between the board/bench control logic and the gate-level function.

Parameters:
- N_IN, 3, number of function inputs; vector width.
- SETTLE, 2, cycles each vector is held before sampling; legal range ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE.
- abort  input  1  cancel a running sweep.
- expected  input  2**N_IN  expected truth table; bit i = F(vector i); captured on accepted start.
- f_in  input  1  output of the function under test.
- vec_out  output  N_IN  input vector driven to the function; MSB = first input (x), LSB = last (z).
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  2**N_IN  captured truth table.
- match  output  1  table_out == captured expected; valid from done until next accepted start.
- ones_cnt  output  N_IN+1  number of 1 bits in table_out.

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-high (rst).
- Reset values: state=IDLE, vec_out=0, busy=0, done=0, table_out=0, match=0, ones_cnt=0, settle counter=0, expected register=0.
- States: IDLE, APPLY, SAMPLE.
- IDLE:
  - start=1 at edge k → APPLY; vec_out=0, busy=1.
  - Same edge clears table_out, match and ones_cnt, and captures expected.
- APPLY: holds vec_out for SETTLE cycles using a down counter, then goes to SAMPLE.
- SAMPLE: at its exit edge, table_out[vec_out] <= f_in.
  - If vec_out != 2^N-1: vec_out increments and the state returns to APPLY.
  - Else → IDLE; busy=0, done=1 for that cycle; match and ones_cnt are updated from the final table.
- Latency: each vector takes SETTLE+1 cycles. done is high after edge k + 2^N*(SETTLE+1); for the defaults this is k+24.
- Final vector: vec_out returns to 0 at the edge where done rises.
- start while busy: ignored; the expected register is not recaptured.
- start in the same cycle done is high: the FSM is already in IDLE, so start is accepted normally.
- abort: when busy, abort → IDLE at the next edge.
  - busy=0, vec_out=0; done is not pulsed and match=0.
  - table_out keeps the partial contents; unsampled bits stay 0.
  - abort has priority over a final-sample completion in the same cycle.
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Async reset mid-sweep: all outputs return to their reset values immediately; the sweep does not resume.
- Widths:
  - ones_cnt is N_IN+1 bits, so 2^N fits (8 → 4'b1000).
  - vec_out increment never wraps inside a sweep.
- f_in is treated as a synchronous input; the function under test must settle within SETTLE cycles.

Decomposition:
- Shared header truth_table_defs.vh holds:
  - state encodings IDLE=2'd0, APPLY=2'd1, SAMPLE=2'd2 (2'd3 illegal, recovers to IDLE);
  - SETTLE default.
- One natural sub-module: settle_timer. It is a loadable down counter with load/zero signals, sized $clog2(SETTLE+1).
- The popcount is combinational inside the top module.
- The function under test stays external and is instantiated beside the sweeper in the bench and top level.

Test Plan:
- Reset:
  - Stimulus: assert rst with no clock edges.
  - Required response: all outputs 0; after release, idle outputs stay 0 with start=0.
- Nominal sweep:
  - Stimulus: bench function F = x'y'z + x'yz + xy'; expected=8'h3A; start pulse at edge k.
  - Required response: vec_out visits 0..7, each held 3 cycles; done at k+24; table_out=8'h3A; match=1; ones_cnt=4; busy high for 24 cycles.
- Mismatch:
  - Stimulus: same function; expected=8'h3B.
  - Required response: table_out=8'h3A; match=0; ones_cnt=4.
- Start ignored while busy:
  - Stimulus: start at k; start again at k+5 with expected changed to 8'h00.
  - Required response: sweep unaffected; done still at k+24; match=1 against 8'h3A.
- Abort:
  - Stimulus: abort at k+10 (vector 3 in APPLY).
  - Required response: busy=0 and vec_out=0 after k+11; no done pulse; table_out=8'h02 (bits 0..2 captured; bit1=1).
- Reset mid-sweep and stuck-high output:
  - Stimulus: assert rst at k+7; then rerun with SETTLE=1 and f_in tied to 1.
  - Required response: after reset all outputs are 0; on the rerun, done at k+16, table_out=8'hFF, ones_cnt=4'd8.
